// File: rtl/dmem_responder.sv
// Word-addressed data-memory responder with configurable wait states.
// One request in flight; a single-cycle response carries read data and an error flag.

module dmem_lane #(
    parameter int AW    = 6,
    parameter int VEC_W = 8
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    idx,
    input  logic [VEC_W-1:0] wdata,
    output logic [VEC_W-1:0] rdata
);
    logic [VEC_W-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) mem[idx] <= wdata;
    end

    assign rdata = mem[idx];
endmodule

module dmem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW        = $clog2(DEPTH_WORDS);
    localparam int NUM_LANES = 4;
    localparam int VEC_W     = 8;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } req_t;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                              state;
    logic [3:0]                          cnt;
    req_t                                req_q;
    req_t                                acc;
    logic                                enter_resp;
    logic                                acc_err;
    logic [AW-1:0]                       acc_idx;
    logic [NUM_LANES-1:0]                lane_we;
    logic [NUM_LANES-1:0][VEC_W-1:0]     lane_wd;
    logic [NUM_LANES-1:0][VEC_W-1:0]     lane_rd;

    assign req_ready = (state == IDLE) && !reset;

    // With zero latency the access happens on the accept edge, so the live
    // inputs are used; otherwise the latched request drives the array.
    always_comb begin
        acc = req_q;
        if (state == IDLE) acc = {req_we, req_addr, req_wdata, req_be};
    end

    assign enter_resp = ((state == IDLE) && req_valid && (LATENCY == 0)) ||
                        ((state == WAIT) && (cnt == 4'd0));
    assign acc_err    = (acc.addr[1:0] != 2'b00) || (acc.addr[31:AW+2] != '0);
    assign acc_idx    = acc.addr[AW+1:2];
    assign lane_wd    = acc.wdata;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign lane_we[i] = enter_resp && !reset && acc.we && acc.be[i] && !acc_err;

        dmem_lane #(.AW(AW), .VEC_W(VEC_W)) u_lane (
            .clk   (clk),
            .we    (lane_we[i]),
            .idx   (acc_idx),
            .wdata (lane_wd[i]),
            .rdata (lane_rd[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            req_q     <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: if (req_valid) begin
                    req_q <= acc;
                    if (LATENCY == 0) begin
                        state <= RESP;
                    end else begin
                        state <= WAIT;
                        cnt   <= 4'(LATENCY - 1);
                    end
                end
                WAIT: if (cnt == 4'd0) state <= RESP;
                      else             cnt   <= cnt - 4'd1;
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
            if (enter_resp) begin
                rsp_valid <= 1'b1;
                rsp_err   <= acc_err;
                rsp_rdata <= (acc.we || acc_err) ? 32'd0 : lane_rd;
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: LATENCY=2 and LATENCY=0 instances, scoreboard of
// expected responses filled at issue time and drained when responses arrive.

module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        vld_a = 1'b0, vld_b = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        rdy_a, rv_a, err_a, rdy_b, rv_b, err_b;
    logic [31:0] rd_a, rd_b;

    int n_chk = 0, n_fail = 0, cyc = 0;

    typedef struct { logic [31:0] rd; logic e; } exp_t;
    exp_t        sb[$];
    logic [31:0] bm [2][64];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(.DEPTH_WORDS(64), .LATENCY(2)) dut_a (
        .clk(clk), .reset(reset), .req_valid(vld_a), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_be(req_be), .req_ready(rdy_a), .rsp_valid(rv_a),
        .rsp_rdata(rd_a), .rsp_err(err_a));

    dmem_responder #(.DEPTH_WORDS(64), .LATENCY(0)) dut_b (
        .clk(clk), .reset(reset), .req_valid(vld_b), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_be(req_be), .req_ready(rdy_b), .rsp_valid(rv_b),
        .rsp_rdata(rd_b), .rsp_err(err_b));

    // Reference model update plus scoreboard push for one request.
    task automatic model_push(input int sel, input bit we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] be);
        exp_t x;
        x.e = (addr[1:0] != 2'b00) || (addr >= 32'd256);
        x.rd = '0;
        if (we) begin
            if (!x.e)
                for (int i = 0; i < 4; i++)
                    if (be[i]) bm[sel][addr[7:2]][8*i +: 8] = wdata[8*i +: 8];
        end else if (!x.e) begin
            x.rd = bm[sel][addr[7:2]];
        end
        sb.push_back(x);
    endtask

    // Drives one request and records what the DUT did; no checking here.
    task automatic xact(input int sel, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        output int t_acc, output int t_rsp, output logic [31:0] rd,
                        output logic e, output int rdy_hi, output int pulses,
                        output logic rdy_after);
        int n;
        model_push(sel, we, addr, wdata, be);
        rd = 'x; e = 1'bx;
        @(negedge clk);
        req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        if (sel == 0) vld_a = 1'b1; else vld_b = 1'b1;
        t_acc = -1; n = 0;
        while (t_acc < 0 && n < 50) begin
            if ((sel == 0) ? rdy_a : rdy_b) t_acc = cyc;
            else begin @(negedge clk); n++; end
        end
        @(posedge clk); #1;
        vld_a = 1'b0; vld_b = 1'b0;
        t_rsp = -1; rdy_hi = 0; pulses = 0; n = 0;
        while (t_rsp < 0 && n < 40) begin
            @(negedge clk); n++;
            if ((sel == 0) ? rdy_a : rdy_b) rdy_hi++;
            if ((sel == 0) ? rv_a : rv_b) begin
                pulses++; t_rsp = cyc;
                rd = (sel == 0) ? rd_a : rd_b;
                e  = (sel == 0) ? err_a : err_b;
            end
        end
        @(negedge clk);
        rdy_after = (sel == 0) ? rdy_a : rdy_b;
        if ((sel == 0) ? rv_a : rv_b) pulses++;
    endtask

    int          ta, tr, rh, pc;
    logic [31:0] rd;
    logic        er, ra;
    exp_t        ex;

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++; if (rdy_a !== 1'b0) begin n_fail++; $display("FAIL reset_ready_a got=%b exp=0", rdy_a); end
        n_chk++; if (rdy_b !== 1'b0) begin n_fail++; $display("FAIL reset_ready_b got=%b exp=0", rdy_b); end
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        n_chk++; if (rdy_a !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready_a got=%b exp=1", rdy_a); end
        n_chk++; if (rdy_b !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready_b got=%b exp=1", rdy_b); end
        n_chk++; if ({rv_a, err_a, rd_a} !== 34'd0) begin n_fail++; $display("FAIL reset_outputs got=%b%b%h exp=0", rv_a, err_a, rd_a); end
    endtask

    task automatic test_basic();
        xact(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, ta, tr, rd, er, rh, pc, ra);
        ex = sb.pop_front();
        n_chk++; if (tr - ta !== 3) begin n_fail++; $display("FAIL wr_latency got=%0d exp=3", tr - ta); end
        n_chk++; if (rh !== 0) begin n_fail++; $display("FAIL wr_ready_low got=%0d high cycles exp=0", rh); end
        n_chk++; if (pc !== 1) begin n_fail++; $display("FAIL wr_pulses got=%0d exp=1", pc); end
        n_chk++; if (ra !== 1'b1) begin n_fail++; $display("FAIL wr_ready_back got=%b exp=1", ra); end
        n_chk++; if ({er, rd} !== {ex.e, ex.rd}) begin n_fail++; $display("FAIL wr_rsp got=%b/%h exp=%b/%h", er, rd, ex.e, ex.rd); end
        xact(0, 1'b0, 32'h10, 32'h0, 4'h0, ta, tr, rd, er, rh, pc, ra);
        ex = sb.pop_front();
        n_chk++; if (tr - ta !== 3) begin n_fail++; $display("FAIL rd_latency got=%0d exp=3", tr - ta); end
        n_chk++; if ({er, rd} !== {ex.e, ex.rd}) begin n_fail++; $display("FAIL rd_data got=%b/%h exp=%b/%h", er, rd, ex.e, ex.rd); end
    endtask

    task automatic test_byte_lanes();
        xact(0, 1'b1, 32'h10, 32'h11223344, 4'b0101, ta, tr, rd, er, rh, pc, ra);
        ex = sb.pop_front();
        n_chk++; if ({er, rd} !== {ex.e, ex.rd}) begin n_fail++; $display("FAIL be5_rsp got=%b/%h exp=%b/%h", er, rd, ex.e, ex.rd); end
        xact(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, ta, tr, rd, er, rh, pc, ra);
        ex = sb.pop_front();
        n_chk++; if ({er, rd} !== {ex.e, ex.rd}) begin n_fail++; $display("FAIL be0_rsp got=%b/%h exp=%b/%h", er, rd, ex.e, ex.rd); end
        xact(0, 1'b0, 32'h10, 32'h0, 4'h0, ta, tr, rd, er, rh, pc, ra);
        ex = sb.pop_front();
        n_chk++; if ({er, rd} !== {ex.e, ex.rd}) begin n_fail++; $display("FAIL lanes_read got=%b/%h exp=%b/%h", er, rd, ex.e, ex.rd); end
        n_chk++; if (rd !== 32'hDE22BE44) begin n_fail++; $display("FAIL lanes_const got=%h exp=DE22BE44", rd); end
    endtask

    task automatic test_errors();
        xact(0, 1'b0, 32'h12, 32'h0, 4'h0, ta, tr, rd, er, rh, pc, ra);
        ex = sb.pop_front();
        n_chk++; if ({er, rd} !== {ex.e, ex.rd}) begin n_fail++; $display("FAIL misalign got=%b/%h exp=%b/%h", er, rd, ex.e, ex.rd); end
        n_chk++; if (tr - ta !== 3) begin n_fail++; $display("FAIL err_latency got=%0d exp=3", tr - ta); end
        xact(0, 1'b1, 32'h0, 32'h01020304, 4'hF, ta, tr, rd, er, rh, pc, ra);
        ex = sb.pop_front();
        n_chk++; if ({er, rd} !== {ex.e, ex.rd}) begin n_fail++; $display("FAIL wr0_rsp got=%b/%h exp=%b/%h", er, rd, ex.e, ex.rd); end
        xact(0, 1'b1, 32'h100, 32'h55555555, 4'hF, ta, tr, rd, er, rh, pc, ra);
        ex = sb.pop_front();
        n_chk++; if ({er, rd} !== {ex.e, ex.rd}) begin n_fail++; $display("FAIL oor_rsp got=%b/%h exp=%b/%h", er, rd, ex.e, ex.rd); end
        xact(0, 1'b0, 32'h0, 32'h0, 4'h0, ta, tr, rd, er, rh, pc, ra);
        ex = sb.pop_front();
        n_chk++; if ({er, rd} !== {ex.e, ex.rd}) begin n_fail++; $display("FAIL no_alias got=%b/%h exp=%b/%h", er, rd, ex.e, ex.rd); end
    endtask

    task automatic test_back_to_back();
        int t1 = -1, t2 = -1, r1 = -1, r2 = -1, np = 0;
        logic [31:0] d1 = 'x, d2 = 'x;
        exp_t e1, e2;
        model_push(0, 1'b0, 32'h10, 32'h0, 4'h0);
        model_push(0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        req_we = 1'b0; req_addr = 32'h10; vld_a = 1'b1;
        for (int k = 0; k < 14; k++) begin
            if (rv_a) begin
                np++;
                if (r1 < 0) begin r1 = cyc; d1 = rd_a; end
                else if (r2 < 0) begin r2 = cyc; d2 = rd_a; end
            end
            if (vld_a && rdy_a) begin if (t1 < 0) t1 = cyc; else t2 = cyc; end
            @(posedge clk); #1;
            if (t1 >= 0 && t2 < 0) req_addr = 32'h0;
            if (t2 >= 0) vld_a = 1'b0;
            @(negedge clk);
        end
        vld_a = 1'b0;
        e1 = sb.pop_front(); e2 = sb.pop_front();
        n_chk++; if (t2 - t1 !== 4) begin n_fail++; $display("FAIL b2b_accept got=%0d exp=4", t2 - t1); end
        n_chk++; if (r1 - t1 !== 3) begin n_fail++; $display("FAIL b2b_rsp1 got=%0d exp=3", r1 - t1); end
        n_chk++; if (r2 - t1 !== 7) begin n_fail++; $display("FAIL b2b_rsp2 got=%0d exp=7", r2 - t1); end
        n_chk++; if (np !== 2) begin n_fail++; $display("FAIL b2b_pulses got=%0d exp=2", np); end
        n_chk++; if (d1 !== e1.rd) begin n_fail++; $display("FAIL b2b_d1 got=%h exp=%h", d1, e1.rd); end
        n_chk++; if (d2 !== e2.rd) begin n_fail++; $display("FAIL b2b_d2 got=%h exp=%h", d2, e2.rd); end
    endtask

    task automatic test_reset_abort();
        int t = -1, n = 0, np = 0;
        xact(0, 1'b1, 32'h20, 32'hAAAA5555, 4'hF, ta, tr, rd, er, rh, pc, ra);
        ex = sb.pop_front();
        xact(0, 1'b0, 32'h20, 32'h0, 4'h0, ta, tr, rd, er, rh, pc, ra);
        ex = sb.pop_front();
        n_chk++; if (rd !== ex.rd) begin n_fail++; $display("FAIL abort_pre got=%h exp=%h", rd, ex.rd); end
        @(negedge clk);
        req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_be = 4'hF; vld_a = 1'b1;
        while (t < 0 && n < 50) begin
            if (rdy_a) t = cyc; else begin @(negedge clk); n++; end
        end
        @(posedge clk); #1 vld_a = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        if (rv_a) np++;
        n_chk++; if (rdy_a !== 1'b0) begin n_fail++; $display("FAIL abort_ready_in_reset got=%b exp=0", rdy_a); end
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        n_chk++; if ({rv_a, err_a, rd_a} !== 34'd0) begin n_fail++; $display("FAIL abort_outputs got=%b%b%h exp=0", rv_a, err_a, rd_a); end
        n_chk++; if (rdy_a !== 1'b1) begin n_fail++; $display("FAIL abort_ready got=%b exp=1", rdy_a); end
        for (int k = 0; k < 5; k++) begin @(negedge clk); if (rv_a) np++; end
        n_chk++; if (np !== 0) begin n_fail++; $display("FAIL abort_no_rsp got=%0d exp=0", np); end
        xact(0, 1'b0, 32'h20, 32'h0, 4'h0, ta, tr, rd, er, rh, pc, ra);
        ex = sb.pop_front();
        n_chk++; if (rd !== 32'hAAAA5555 || rd !== ex.rd) begin n_fail++; $display("FAIL abort_mem got=%h exp=%h", rd, ex.rd); end
    endtask

    task automatic test_lat0();
        xact(1, 1'b1, 32'h4, 32'hCAFEF00D, 4'hF, ta, tr, rd, er, rh, pc, ra);
        ex = sb.pop_front();
        n_chk++; if (tr - ta !== 1) begin n_fail++; $display("FAIL l0_wr_latency got=%0d exp=1", tr - ta); end
        n_chk++; if (ra !== 1'b1) begin n_fail++; $display("FAIL l0_wr_ready got=%b exp=1", ra); end
        n_chk++; if (pc !== 1) begin n_fail++; $display("FAIL l0_wr_pulses got=%0d exp=1", pc); end
        n_chk++; if ({er, rd} !== {ex.e, ex.rd}) begin n_fail++; $display("FAIL l0_wr_rsp got=%b/%h exp=%b/%h", er, rd, ex.e, ex.rd); end
        xact(1, 1'b0, 32'h4, 32'h0, 4'h0, ta, tr, rd, er, rh, pc, ra);
        ex = sb.pop_front();
        n_chk++; if (tr - ta !== 1) begin n_fail++; $display("FAIL l0_rd_latency got=%0d exp=1", tr - ta); end
        n_chk++; if (ra !== 1'b1) begin n_fail++; $display("FAIL l0_rd_ready got=%b exp=1", ra); end
        n_chk++; if ({er, rd} !== {ex.e, ex.rd}) begin n_fail++; $display("FAIL l0_rd_data got=%b/%h exp=%b/%h", er, rd, ex.e, ex.rd); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_byte_lanes();
        test_errors();
        test_back_to_back();
        test_reset_abort();
        test_lat0();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder: the memory-side end of the datapath's load/store interface (aluout → address, writedata → write data, readdata ← read data).
- Accepts one word-addressed read or write request at a time over a valid/ready handshake.
- Inserts a configurable number of wait states, then returns a single-cycle response with read data and an error flag.
- Used in place of a zero-latency combinational RAM so the core can be tested against realistic memory timing.

Parameters:
DEPTH_WORDS, 64, number of 32-bit words stored; power of two, 4..4096
LATENCY, 2, wait-state cycles between acceptance and response; 0..15

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_we  input  1  1 = write, 0 = read
req_addr  input  32  byte address
req_wdata  input  32  write data
req_be  input  4  byte enables for writes; bit i covers bits [8i+7:8i]; ignored on reads
req_ready  output  1  responder can accept a request this cycle
rsp_valid  output  1  response valid, exactly one cycle per accepted request
rsp_rdata  output  32  read data; 0 for writes and errored requests
rsp_err  output  1  request was misaligned or out of range

Behaviour:
- Reset (synchronous, sampled at the rising edge):
  - state=IDLE, counter=0.
  - req_ready=1 from the cycle after reset deasserts; it is 0 while reset is high.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Storage array is not cleared; contents are undefined until written.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. On req_valid=1, the request is accepted at the clock edge. On that edge, req_we, req_addr, req_wdata and req_be are latched. Inputs are ignored until the responder returns to IDLE.
  - Transition out of IDLE: if LATENCY=0, go to RESP; otherwise go to WAIT with counter=LATENCY-1.
  - WAIT: req_ready=0. Decrement counter each cycle; when counter=0, go to RESP.
  - RESP: rsp_valid=1 for exactly one cycle, then return to IDLE unconditionally. There is no response back-pressure.
- Memory access:
  - The array read or write is performed at the edge entering RESP.
  - rsp_rdata and rsp_err are registered on that edge and held until the next response or reset.
- Latency:
  - Request accepted in cycle T; rsp_valid is high in cycle T+1+LATENCY.
  - req_ready is high again in cycle T+2+LATENCY.
  - Maximum throughput is one request per LATENCY+2 cycles.
- Addressing:
  - Word index = latched addr[log2(DEPTH_WORDS)+1:2].
  - Error if addr[1:0]≠0, or if addr ≥ DEPTH_WORDS*4. Upper bits are never aliased.
  - On error: no write, rsp_rdata=0, rsp_err=1. The response still occurs with normal latency.
- Writes:
  - Only lanes with be=1 are updated.
  - be=4'b0000 leaves memory unchanged with no error.
  - rsp_rdata=0 for all writes.
- Reads:
  - Return the full 32-bit word.
  - A read issued after a write's rsp_valid observes that write.
- Reset mid-operation:
  - Reset in IDLE, WAIT, or in the cycle whose edge would enter RESP aborts the request: no memory write, no rsp_valid. Reset has priority over the state transition.
  - Reset during RESP: memory is already updated; outputs clear at that edge.
- req_valid asserted while req_ready=0 is not an error. The request is simply accepted later if still held.

Test Plan:
- LATENCY=2, after reset, write 0xDEADBEEF to 0x10 with be=4'hF, accepted cycle T -> req_ready=0 in T+1..T+3, rsp_valid=1 only in T+3, rsp_err=0, rsp_rdata=0; then read 0x10 -> rsp_rdata=0xDEADBEEF three cycles after acceptance.
- Byte lanes: over 0xDEADBEEF at 0x10, write 0x11223344 with be=4'b0101; then write be=0 with 0xFFFFFFFF -> read 0x10 returns 0xDE22BE44, rsp_err=0 throughout.
- Errors: read 0x12 -> rsp_err=1, rsp_rdata=0; write 0x55555555 to 0x100 (DEPTH_WORDS=64) -> rsp_err=1, read of 0x0 unchanged (no aliasing).
- Back-to-back: req_valid held high across two reads -> second accepted in T+4, responses in T+3 and T+7, exactly one rsp_valid pulse each.
- Reset abort: 0x20 holds 0xAAAA5555; write 0x12345678 to 0x20, assert reset in T+2 (WAIT) -> no rsp_valid, all outputs 0, req_ready=1 the cycle after reset drops, read 0x20 returns 0xAAAA5555.
- LATENCY=0 instance: write then read 0x4 with 0xCAFEF00D -> each rsp_valid in T+1, req_ready back in T+2, read data 0xCAFEF00D.
